// File: rtl/serial_frame_router.sv
// serial_frame_router: frame sequencer for the 1-to-4 serial demultiplexer.
// Decodes start bit, 2-bit address (MSB first), DATA_BITS data bits
// (LSB first), optional even-parity bit and stop bit from Ser_In, drives
// the demux select and data-phase enable, and reports per-port completion.
// Optional feature macro: SERIAL_FRAME_PARITY_EN (adds the parity bit,
// PARITY state and a functional parity_err; otherwise parity_err is 0).
module serial_frame_router #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Ser_In,
  output logic [1:0]           port_num,
  output logic                 data_en,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic [3:0]           port_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef SERIAL_FRAME_PARITY_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic                 addr_msb;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic                 par_acc;
  logic                 stop_par_bad;

  // Data enters at the MSB end so the first (LSB) bit ends up at bit 0.
  if (DATA_BITS > 1) begin : g_shift_wide
    assign shreg_next = {Ser_In, shreg[DATA_BITS-1:1]};
  end else begin : g_shift_one
    assign shreg_next = Ser_In;
  end

`ifdef SERIAL_FRAME_PARITY_EN
  logic par_bad;
  assign stop_par_bad = par_bad;
`else
  assign stop_par_bad = 1'b0;
  assign parity_err   = 1'b0;
`endif

  assign data_en = (state == DATA);
  assign busy    = (state != IDLE);

  // Frame sequencer with registered select, data word and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      addr_msb   <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      port_num   <= 2'b00;
      data_out   <= '0;
      port_valid <= '0;
      frame_err  <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      port_valid <= '0;
      frame_err  <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!Ser_In) begin
            state   <= ADDR;
            bit_cnt <= '0;
          end
        end
        ADDR: begin
          if (bit_cnt == '0) begin
            addr_msb <= Ser_In;
            bit_cnt  <= CNT_ONE;
          end else begin
            port_num <= {addr_msb, Ser_In};
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          shreg   <= shreg_next;
          par_acc <= par_acc ^ Ser_In;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
            state   <= PARITY;
`else
            state   <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        PARITY: begin
          par_bad <= (Ser_In != par_acc);
          state   <= STOP;
        end
`endif
        STOP: begin
          frame_err <= !Ser_In;
`ifdef SERIAL_FRAME_PARITY_EN
          parity_err <= par_bad;
          par_bad    <= 1'b0;
`endif
          if (Ser_In && !stop_par_bad) begin
            data_out   <= shreg;
            port_valid <= 4'b0001 << port_num;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_router.sv
// Self-checking bench for serial_frame_router (DATA_BITS = 8).
// Reference model parses the driven bit stream frame by frame and predicts
// per-cycle busy/data_en/pulses/data_out and the select during data bits.
module tb_serial_frame_router;

  localparam int DB = 8;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FL = DB + 5;
`else
  localparam int FL = DB + 4;
`endif
  localparam int MAXN = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Ser_In = 1'b1;
  logic [1:0]    port_num;
  logic          data_en;
  logic          busy;
  logic [DB-1:0] data_out;
  logic [3:0]    port_valid;
  logic          frame_err;
  logic          parity_err;

  serial_frame_router #(.DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .Ser_In     (Ser_In),
    .port_num   (port_num),
    .data_en    (data_en),
    .busy       (busy),
    .data_out   (data_out),
    .port_valid (port_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            stim[$];
  // ctl = {busy, data_en, port_valid[3:0], frame_err, parity_err}
  logic [7:0]    exp_ctl [MAXN];
  logic [DB-1:0] exp_dout[MAXN];
  logic [1:0]    exp_port[MAXN];
  logic [7:0]    obs_ctl [MAXN];
  logic [DB-1:0] obs_dout[MAXN];
  logic [1:0]    obs_port[MAXN];
  logic          upd     [MAXN];
  logic [DB-1:0] updv    [MAXN];
  logic [DB-1:0] cur_dout = '0;

  task automatic add_idle(input int n);
    for (int j = 0; j < n; j++) stim.push_back(1'b1);
  endtask

  task automatic add_frame(input logic [1:0] a, input logic [DB-1:0] d,
                           input logic pbit, input logic stopb);
    stim.push_back(1'b0);
    stim.push_back(a[1]);
    stim.push_back(a[0]);
    for (int j = 0; j < DB; j++) stim.push_back(d[j]);
`ifdef SERIAL_FRAME_PARITY_EN
    stim.push_back(pbit);
`else
    if (pbit === 1'bz) stim.push_back(1'b1);
`endif
    stim.push_back(stopb);
  endtask

  // Frame-level reference: walk the stream, find start bits, decode fields.
  task automatic build_model();
    int n = stim.size();
    int i = 0;
    int p;
    logic [1:0]    a;
    logic [DB-1:0] d;
    logic          ok_par;
    logic          stopb;
    logic [DB-1:0] dv;
    for (int k = 0; k < n; k++) begin
      exp_ctl[k] = '0; exp_port[k] = '0; upd[k] = 1'b0; updv[k] = '0;
    end
    while (i < n) begin
      if (stim[i]) begin
        i++;
      end else begin
        if (i + FL >= n) break;
        a = {stim[i+1], stim[i+2]};
        for (int j = 0; j < DB; j++) d[j] = stim[i+3+j];
        ok_par = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
        ok_par = ((^d) == stim[i+3+DB]);
`endif
        stopb = stim[i+FL-1];
        for (int j = 1; j < FL; j++) exp_ctl[i+j][7] = 1'b1;
        for (int j = 0; j < DB; j++) begin
          exp_ctl[i+3+j][6] = 1'b1;
          exp_port[i+3+j] = a;
        end
        p = i + FL;
        if (!stopb) exp_ctl[p][1] = 1'b1;
        if (!ok_par) exp_ctl[p][0] = 1'b1;
        if (stopb && ok_par) begin
          exp_ctl[p][2+a] = 1'b1;
          upd[p] = 1'b1;
          updv[p] = d;
        end
        i += FL;
      end
    end
    dv = cur_dout;
    for (int k = 0; k < n; k++) begin
      if (upd[k]) dv = updv[k];
      exp_dout[k] = dv;
    end
    cur_dout = dv;
  endtask

  // Present one bit per cycle, record outputs on the falling edge.
  task automatic drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      Ser_In = stim[k];
      @(negedge clk);
      obs_ctl[k]  = {busy, data_en, port_valid, frame_err, parity_err};
      obs_dout[k] = data_out;
      obs_port[k] = port_num;
      @(posedge clk); #1;
    end
    Ser_In = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({port_num, data_en, busy, data_out, port_valid, frame_err, parity_err} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got pn=%b en=%b busy=%b dout=%h pv=%b fe=%b pe=%b, required all 0",
               port_num, data_en, busy, data_out, port_valid, frame_err, parity_err);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    stim = {};
    add_idle(2);
    add_frame(2'b11, 8'hFF, 1'b0, 1'b1);
    stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    stim.push_back(1'b1); stim.push_back(1'b1);
    drive_stream();
    checks++;
    if ({busy, data_en, port_num, data_out} !== {1'b1, 1'b1, 2'b11, 8'hFF}) begin
      errors++;
      $display("FAIL reset_precondition: got busy=%b en=%b pn=%b dout=%h, required 1 1 11 ff",
               busy, data_en, port_num, data_out);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({port_num, data_en, busy, data_out, port_valid, frame_err, parity_err} !== '0) begin
      errors++;
      $display("FAIL reset_async: got pn=%b en=%b busy=%b dout=%h pv=%b fe=%b pe=%b, required all 0",
               port_num, data_en, busy, data_out, port_valid, frame_err, parity_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cur_dout = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || port_valid !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got busy=%b pv=%b, required 0 0000", k, busy, port_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_port2();
    int hits = 0;
    stim = {};
    add_idle(2);
    add_frame(2'b10, 8'hA5, 1'b0, 1'b1);
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL basic_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin
        errors++; $display("FAIL basic_dout c%0d: got %h required %h", k, obs_dout[k], exp_dout[k]);
      end
      if (exp_ctl[k][6]) begin
        checks++;
        if (obs_port[k] !== 2'b10) begin
          errors++; $display("FAIL basic_port c%0d: got %b required 10", k, obs_port[k]);
        end
      end
      if (obs_ctl[k][5:2] == 4'b0100) hits++;
    end
    checks++;
    if (hits !== 1 || obs_dout[stim.size()-1] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_result: got pulses=%0d dout=%h required 1 a5", hits, obs_dout[stim.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int p1 = -1;
    int p2 = -1;
    int first_busy = -1;
    int last_busy = -1;
    int gaps = 0;
    stim = {};
    add_idle(1);
    add_frame(2'b00, 8'h3C, 1'b0, 1'b1);
    add_frame(2'b11, 8'hFF, 1'b0, 1'b1);
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL b2b_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin
        errors++; $display("FAIL b2b_dout c%0d: got %h required %h", k, obs_dout[k], exp_dout[k]);
      end
      if (exp_ctl[k][6]) begin
        checks++;
        if (obs_port[k] !== exp_port[k]) begin
          errors++; $display("FAIL b2b_port c%0d: got %b required %b", k, obs_port[k], exp_port[k]);
        end
      end
      if (obs_ctl[k][5:2] == 4'b0001 && p1 < 0) p1 = k;
      if (obs_ctl[k][5:2] == 4'b1000 && p2 < 0) p2 = k;
      if (obs_ctl[k][7]) begin
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
    end
    for (int k = first_busy; k <= last_busy && first_busy >= 0; k++)
      if (!obs_ctl[k][7]) gaps++;
    checks++;
    if (p1 < 0 || p2 - p1 != FL) begin
      errors++; $display("FAIL b2b_spacing: got p1=%0d p2=%0d required spacing %0d", p1, p2, FL);
    end
    checks++;
    if (gaps != 1) begin
      errors++; $display("FAIL b2b_busy_gap: got %0d idle cycles required 1", gaps);
    end
  endtask

  task automatic test_frame_error();
    logic [DB-1:0] prior = cur_dout;
    int fe_cnt = 0;
    int pv_cnt = 0;
    stim = {};
    add_idle(2);
    add_frame(2'b10, 8'hA5, 1'b0, 1'b0);
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL ferr_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== prior) begin
        errors++; $display("FAIL ferr_dout c%0d: got %h required %h", k, obs_dout[k], prior);
      end
      if (obs_ctl[k][1]) fe_cnt++;
      if (obs_ctl[k][5:2] != 4'b0000) pv_cnt++;
    end
    checks++;
    if (fe_cnt != 1 || pv_cnt != 0) begin
      errors++; $display("FAIL ferr_pulses: got fe=%0d pv=%0d required 1 0", fe_cnt, pv_cnt);
    end
  endtask

`ifdef SERIAL_FRAME_PARITY_EN
  task automatic test_parity_error();
    int pe_cnt = 0;
    int pv_cnt = 0;
    stim = {};
    add_idle(2);
    add_frame(2'b10, 8'hA5, 1'b1, 1'b1);
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL perr_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin
        errors++; $display("FAIL perr_dout c%0d: got %h required %h", k, obs_dout[k], exp_dout[k]);
      end
      if (obs_ctl[k][0]) pe_cnt++;
      if (obs_ctl[k][5:2] != 4'b0000) pv_cnt++;
    end
    checks++;
    if (pe_cnt != 1 || pv_cnt != 0) begin
      errors++; $display("FAIL perr_pulses: got pe=%0d pv=%0d required 1 0", pe_cnt, pv_cnt);
    end
  endtask
`endif

  task automatic test_mid_frame_reset();
    int pv_cnt = 0;
    int pv_bad = 0;
    stim = {};
    add_idle(1);
    stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    drive_stream();
    Ser_In = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    Ser_In = 1'b1;
    cur_dout = '0;
    stim = {};
    add_idle(2);
    add_frame(2'b01, 8'h5A, 1'b0, 1'b1);
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL midrst_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin
        errors++; $display("FAIL midrst_dout c%0d: got %h required %h", k, obs_dout[k], exp_dout[k]);
      end
      if (obs_ctl[k][5:2] != 4'b0000) begin
        pv_cnt++;
        if (obs_ctl[k][5:2] != 4'b0010) pv_bad++;
      end
    end
    checks++;
    if (pv_cnt != 1 || pv_bad != 0 || obs_dout[stim.size()-1] !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_result: got pulses=%0d wrong=%0d dout=%h required 1 0 5a",
               pv_cnt, pv_bad, obs_dout[stim.size()-1]);
    end
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic [1:0]    a;
    stim = {};
    add_idle(1);
    for (int f = 0; f < 16; f++) begin
      add_idle(int'($urandom_range(0, 3)));
      a = 2'($urandom_range(0, 3));
      d = DB'($urandom);
      add_frame(a, d, (^d) ^ ($urandom_range(0, 4) == 0),
                $urandom_range(0, 5) != 0);
    end
    add_idle(3);
    build_model();
    drive_stream();
    for (int k = 0; k < stim.size(); k++) begin
      checks++;
      if (obs_ctl[k] !== exp_ctl[k]) begin
        errors++; $display("FAIL rand_ctl c%0d: got %b required %b", k, obs_ctl[k], exp_ctl[k]);
      end
      checks++;
      if (obs_dout[k] !== exp_dout[k]) begin
        errors++; $display("FAIL rand_dout c%0d: got %h required %h", k, obs_dout[k], exp_dout[k]);
      end
      if (exp_ctl[k][6]) begin
        checks++;
        if (obs_port[k] !== exp_port[k]) begin
          errors++; $display("FAIL rand_port c%0d: got %b required %b", k, obs_port[k], exp_port[k]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_port2();
    test_back_to_back();
    test_frame_error();
`ifdef SERIAL_FRAME_PARITY_EN
    test_parity_error();
`endif
    test_mid_frame_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
